// File: rtl/seq_det_pkg.sv
// Shared defaults for the programmable sequence detector: the reset pattern
// (the legacy 1-0-2-2-1-0 detector), default widths and the length-mask helper.
package seq_det_pkg;

  localparam int DEF_SYM_W   = 4;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_LEN     = 6;
  localparam int MASK_W      = 32;

  localparam int DEF_PAT [DEF_LEN] = '{1, 0, 2, 2, 1, 0};

  // Reset value of pattern slot k; slots past the legacy pattern hold 0.
  function automatic int def_pat_sym(input int k);
    int v;
    v = 0;
    if (k >= 0 && k < DEF_LEN) v = DEF_PAT[k];
    return v;
  endfunction

  // Bit k set for every slot k below the active length.
  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    if (len <= 0)           m = '0;
    else if (len >= MASK_W) m = '1;
    else                    m = (MASK_W'(1) << len) - MASK_W'(1);
    return m;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Symbol history and fill counter. The window presented to the comparator is the
// history as it will look after the incoming symbol is shifted in (slot 0 = newest).
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         shift_en,
  input  logic                         fill_clr,
  input  logic [SYM_W-1:0]             in_sym,
  output logic [MAX_LEN*SYM_W-1:0]     win,
  output logic [$clog2(MAX_LEN+1)-1:0] fill
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  // The newest window slot is always the incoming symbol, so only the
  // MAX_LEN-1 older symbols need storage.
  logic [(MAX_LEN-1)*SYM_W-1:0] hist;

  assign win = {hist, in_sym};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift_en) hist <= win[(MAX_LEN-1)*SYM_W-1:0];
      if (fill_clr)
        fill <= '0;
      else if (shift_en && fill != LEN_W'(MAX_LEN))
        fill <= fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Run-time programmable sequence detector: pattern/length registers, L-way
// comparator against the next-state history window, match pulse and saturating counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [SYM_W-1:0]             in_sym,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0]   cfg_addr,
  input  logic [SYM_W-1:0]             cfg_sym,
  input  logic                         cfg_len_we,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         overlap_en,
  input  logic                         clr_cnt,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(MAX_LEN+1)-1:0] fill
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  if (MAX_LEN < DEF_LEN || MAX_LEN > MASK_W) begin : g_bad_max_len
    $error("seq_det_param: MAX_LEN must lie in 6..32");
  end

  logic [SYM_W-1:0]         pat [MAX_LEN];
  logic [LEN_W-1:0]         len;
  logic [MAX_LEN*SYM_W-1:0] win;
  logic [MAX_LEN-1:0]       eq;
  logic [MAX_LEN-1:0]       mask;
  logic                     len_ok;
  logic                     cfg_wr;
  logic                     shift_en;
  logic                     fill_clr;
  logic                     hit_p0;

  assign len_ok   = cfg_len_we && (int'(cfg_len) <= MAX_LEN);
  assign cfg_wr   = cfg_we || len_ok;
  assign shift_en = in_valid && !cfg_wr;
  assign fill_clr = cfg_wr || (hit_p0 && !overlap_en);

  seq_det_hist #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .fill_clr (fill_clr),
    .in_sym   (in_sym),
    .win      (win),
    .fill     (fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LEN; k++) pat[k] <= SYM_W'(def_pat_sym(k));
      len <= LEN_W'(DEF_LEN);
    end else begin
      if (cfg_we && int'(cfg_addr) < MAX_LEN) pat[cfg_addr] <= cfg_sym;
      if (len_ok) len <= cfg_len;
    end
  end

  // Pattern slot L-1 lines up with window slot 0 (the incoming symbol).
  always_comb begin
    eq = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(len))
        eq[k] = (pat[k] == win[(int'(len) - 1 - k)*SYM_W +: SYM_W]);
    end
  end

  assign mask   = MAX_LEN'(len_mask(int'(len)));
  assign hit_p0 = in_valid && !cfg_wr && (len != '0) &&
                  (int'(fill) + 1 >= int'(len)) && (&(eq | ~mask));

  // ---- stage p0 -> registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= hit_p0;
      if (clr_cnt)
        match_cnt <= '0;
      else if (hit_p0 && match_cnt != '1)
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: spec-derived match tables plus a queue-based scoreboard
// fed by an independent symbol-list model; a second instance has a 2-bit counter.
module tb_seq_det_param;

  localparam int SYM_W   = 4;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int ADDR_W  = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic [SYM_W-1:0]   in_sym;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [SYM_W-1:0]   cfg_sym;
  logic               cfg_len_we;
  logic [LEN_W-1:0]   cfg_len;
  logic               overlap_en;
  logic               clr_cnt;
  logic               match, match2;
  logic [15:0]        match_cnt;
  logic [1:0]         match_cnt2;
  logic [LEN_W-1:0]   fill, fill2;

  always #5 clk = ~clk;

  seq_det_param #(.SYM_W(4), .MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sym(cfg_sym),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt), .fill(fill)
  );

  seq_det_param #(.SYM_W(4), .MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sym(cfg_sym),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .clr_cnt(clr_cnt), .match(match2), .match_cnt(match_cnt2), .fill(fill2)
  );

  typedef struct { bit m; int cnt; int cnt2; int fill; } exp_t;
  typedef struct { int sym; bit m_ovl; bit m_novl; } vec_t;

  exp_t exp_q [$];
  vec_t tbl [20];
  int   m_pat [MAX_LEN];
  int   m_len;
  int   m_hist [$];
  int   m_cnt, m_cnt2;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = '{1, 0, 2, 2, 1, 0, 0, 0};
    m_len = 6;
    m_hist.delete();
    m_cnt  = 0;
    m_cnt2 = 0;
    exp_q.delete();
  endtask

  // Drive one cycle, predict, push expectation, then pop and check after the edge.
  task automatic step(input bit v, input int s, input bit we = 0, input int addr = 0,
                      input int csym = 0, input bit lwe = 0, input int len = 0,
                      input bit clr = 0);
    bit   cw, h;
    exp_t e;
    in_valid = v;  in_sym = SYM_W'(s);
    cfg_we = we;   cfg_addr = ADDR_W'(addr); cfg_sym = SYM_W'(csym);
    cfg_len_we = lwe; cfg_len = LEN_W'(len); clr_cnt = clr;
    cw = we || (lwe && len <= MAX_LEN);
    h  = 1'b0;
    if (cw) begin
      if (we) m_pat[addr] = csym;
      if (lwe && len <= MAX_LEN) m_len = len;
      m_hist.delete();
    end else if (v) begin
      m_hist.push_back(s);
      if (m_hist.size() > MAX_LEN) m_hist.delete(0);
      if (m_len >= 1 && m_hist.size() >= m_len) begin
        h = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - m_len + k] != m_pat[k]) h = 1'b0;
      end
      if (h && !overlap_en) m_hist.delete();
    end
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (h) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    exp_q.push_back('{m: h, cnt: m_cnt, cnt2: m_cnt2, fill: m_hist.size()});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_match",  int'(match),      int'(e.m));
      chk("sb_cnt",    int'(match_cnt),  e.cnt);
      chk("sb_fill",   int'(fill),       e.fill);
      chk("sb_match2", int'(match2),     int'(e.m));
      chk("sb_cnt2",   int'(match_cnt2), e.cnt2);
      chk("sb_fill2",  int'(fill2),      e.fill);
    end
  endtask

  task automatic do_reset();
    in_valid = 0; in_sym = '0; cfg_we = 0; cfg_addr = '0; cfg_sym = '0;
    cfg_len_we = 0; cfg_len = '0; clr_cnt = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_match", int'(match), 0);
    chk("rst_cnt",   int'(match_cnt), 0);
    chk("rst_fill",  int'(fill), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int stream [20] = '{7, 5, 1, 0, 2, 2, 1, 0, 2, 2, 1, 0, 3, 9, 2, 1, 0, 2, 2, 8};
    int abc [8]     = '{10, 11, 12, 11, 12, 10, 11, 12};
    int pre [5]     = '{1, 0, 2, 2, 1};
    int def6 [6]    = '{1, 0, 2, 2, 1, 0};
    int f_before;

    for (int i = 0; i < 20; i++) begin
      tbl[i].sym    = stream[i];
      tbl[i].m_ovl  = (i == 7 || i == 11);
      tbl[i].m_novl = (i == 7);
    end
    overlap_en = 1'b1;

    // Default pattern, overlap on
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, tbl[i].sym);
      chk($sformatf("ovl_match[%0d]", i), int'(match), int'(tbl[i].m_ovl));
    end
    chk("ovl_cnt", int'(match_cnt), 2);

    // Same stream, overlap off
    overlap_en = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, tbl[i].sym);
      chk($sformatf("novl_match[%0d]", i), int'(match), int'(tbl[i].m_novl));
      if (i == 7) chk("novl_fill_after_match", int'(fill), 0);
    end
    chk("novl_cnt", int'(match_cnt), 1);

    // Gapped input
    overlap_en = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 3)) begin
        step(0, 15);
        chk("gap_idle_match", int'(match), 0);
      end
      step(1, tbl[i].sym);
      chk($sformatf("gap_match[%0d]", i), int'(match), int'(tbl[i].m_ovl));
    end
    chk("gap_cnt", int'(match_cnt), 2);

    // Reprogram to A,B,C (length written with the last slot)
    do_reset();
    for (int i = 0; i < 6; i++) step(1, def6[i]);
    step(0, 0, 1, 0, 10);
    step(0, 0, 1, 1, 11);
    step(0, 0, 1, 2, 12, 1, 3);
    chk("prog_fill_cleared", int'(fill), 0);
    for (int j = 0; j < 8; j++) begin
      step(1, abc[j]);
      chk($sformatf("prog_match[%0d]", j), int'(match), int'(j == 2 || j == 7));
    end
    f_before = int'(fill);
    step(0, 0, 0, 0, 0, 1, 9);
    chk("len9_ignored_fill", int'(fill), f_before);
    step(1, 12, 1, 2, 12);
    chk("cfg_wins_match", int'(match), 0);
    chk("cfg_wins_fill", int'(fill), 0);
    for (int j = 0; j < 3; j++) step(1, abc[j]);
    chk("len3_still_active", int'(match), 1);

    // Counter saturation with L=1 pattern {5}
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 5, 1, 1);
    for (int j = 0; j < 6; j++) begin
      step(1, 5);
      chk("l1_b2b_match", int'(match), 1);
    end
    chk("sat_cnt2", int'(match_cnt2), 3);
    chk("cnt16_six", int'(match_cnt), 6);
    step(1, 5, 0, 0, 0, 0, 0, 1);
    chk("clr_hit_match", int'(match), 1);
    chk("clr_hit_cnt", int'(match_cnt), 0);
    chk("clr_hit_cnt2", int'(match_cnt2), 0);

    // Async reset mid-stream, pattern reverts to default
    for (int j = 0; j < 5; j++) step(1, pre[j]);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_match", int'(match), 0);
    chk("async_cnt",   int'(match_cnt), 0);
    chk("async_fill",  int'(fill), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0);
    chk("post_rst_no_match", int'(match), 0);
    for (int j = 0; j < 6; j++) step(1, def6[j]);
    chk("post_rst_default_len6", int'(match), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised, run-time programmable sequence detector for the task FSM datapath. It generalises the fixed 1-0-2-2-1-0 detector:
- symbol width, maximum pattern length and counter width are parameters;
- the pattern and its length load through a config port;
- overlap and non-overlap matching are selectable;
- input is qualified by a valid strobe;
- a registered match pulse and a saturating match counter are provided.

It sits between the symbol source and the result/scoring logic.

## Interface
- `SYM_W`, 4, symbol width in bits
- `MAX_LEN`, 8, maximum pattern length in symbols; must be ≥ 6 (elaboration-time check)
- `CNT_W`, 16, match counter width
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  `in_sym` is accepted on this edge
- `in_sym`  in  `SYM_W`  input symbol
- `cfg_we`  in  1  write `cfg_sym` into pattern slot `cfg_addr`
- `cfg_addr`  in  `$clog2(MAX_LEN)`  pattern slot; 0 = oldest/first symbol
- `cfg_sym`  in  `SYM_W`  pattern symbol data
- `cfg_len_we`  in  1  write `cfg_len`
- `cfg_len`  in  `$clog2(MAX_LEN+1)`  active pattern length, 0..`MAX_LEN`
- `overlap_en`  in  1  1 = overlapping matches allowed; 0 = history cleared after each match
- `clr_cnt`  in  1  synchronous clear of `match_cnt`
- `match`  out  1  one-cycle registered match pulse
- `match_cnt`  out  `CNT_W`  saturating count of matches
- `fill`  out  `$clog2(MAX_LEN+1)`  number of valid symbols in history

## Operation
- **History:** shift register of `MAX_LEN` symbols plus a `fill` counter. On each accepted symbol (`in_valid`=1), the history shifts and `in_sym` enters as the newest entry. `fill` increments and saturates at `MAX_LEN`.
- **Compare:** let L = active length. Compare the newest L symbols, including the symbol being accepted, against pattern slots 0..L-1 (slot L-1 = newest). A hit requires all of:
  - `in_valid`=1;
  - L ≥ 1;
  - `fill`+1 ≥ L.
- **Hit, `overlap_en`=1:** history and `fill` update normally.
- **Hit, `overlap_en`=0:** `fill` is forced to 0 on that edge, so the next match needs L fresh symbols.
- **Idle cycles:** cycles with `in_valid`=0 leave history, `fill` and the state unchanged; gaps never break a sequence.
- **Config writes:**
  - `cfg_we` or `cfg_len_we` clears `fill` to 0 and suppresses the match on that edge.
  - An `in_sym` presented on the same edge is dropped; config wins.
  - `cfg_len_we` with `cfg_len` > `MAX_LEN` is ignored entirely (no clear).
  - Both writes on the same edge: both take effect.
- **Counter:**
  - `match_cnt` increments on each hit and saturates at all-ones, with no wrap.
  - `clr_cnt` wins over a simultaneous hit: the count becomes 0, but `match` still pulses.
  - Config writes do not touch `match_cnt`.
- **Reset values:**
  - `match`=0, `match_cnt`=0, `fill`=0;
  - history = all zeros;
  - pattern slots 0..5 = 1,0,2,2,1,0; remaining slots 0;
  - length = 6.
- **Reset mid-stream:** partial sequence discarded; the pattern reverts to the default above.

## Timing
- `match` is registered: it is high for exactly the cycle following the edge that accepts the final pattern symbol.
- `match_cnt` and `fill` update on the same edge as the `match` register.
- Back-to-back matches are possible on consecutive cycles, e.g. L=1 or a repeating pattern with overlap on.
- Config takes effect for the symbol accepted on the edge after the write edge.
- Combinational path: an L-way `SYM_W` equality reduce plus a length mask. No multi-cycle paths.

## Structure
- **Package `seq_det_pkg`:**
  - default pattern constant array (1,0,2,2,1,0);
  - default length 6;
  - default `SYM_W`, `MAX_LEN`, `CNT_W`;
  - a function computing the length mask.
- **Sub-module `seq_det_hist`:**
  - history shift register, `fill` counter and clear/saturate logic;
  - exposes the next-state history window to the top-level comparator.
- **Top level:** pattern/length registers, comparator, `match` register, counter.

## Test plan
- **Default pattern, overlap on:** after reset, feed 7,5,1,0,2,2,1,0,2,2,1,0,3,9,2,1,0,2,2,8 (`in_valid`=1 every cycle). Expect `match` pulses after symbol indices 7 and 11 only, then `match_cnt`=2.
- **Same stream, `overlap_en`=0:** a single pulse after index 7, then `match_cnt`=1. Check `fill`=0 the cycle after the match.
- **Gapped input:** same stream with `in_valid` low for 1–3 random cycles between symbols. Expect the same match positions in symbol order and `match_cnt`=2.
- **Reprogram:**
  - Write slots 0..2 = 0xA,0xB,0xC and length 3 → `fill`=0.
  - Feed A,B,C,B,C,A,B,C → pulses after the 3rd and 8th symbol.
  - Write length 9 (> `MAX_LEN`) → ignored; `fill` not cleared.
- **Counter edges:** with `CNT_W`=2 and L=1 pattern {5}, feed 5 six times → `match_cnt` sticks at 3. Assert `clr_cnt` with a hit → count 0 and `match`=1.
- **Async reset:**
  - Drop `rst_n` after 1,0,2,2,1; release; feed 0 → no match.
  - All outputs read 0 during reset; length reads back as 6.
